decoder_nx2n_scan: RTL and testbench

Parametrised N-to-2^N one-hot decoder with a registered output and two operating modes. In direct mode it decodes a validated binary select into one-hot. In scan mode it walks the one-hot output through all 2^N positions on its own, holding each position for a programmable dwell. It sits between control logic and row/strobe/chip-select fan-out (display row drive, keypad scan, bank select) and replaces the fixed-width combinational 2-to-4 decoders.

---
 rtl/decoder_nx2n_scan.sv | 90 +++++++++
 tb/tb_decoder_nx2n_scan.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/decoder_nx2n_scan.sv
// decoder_nx2n_scan: N-to-2^N one-hot decoder with a registered output.
// In direct mode it decodes a validated binary select. In scan mode it
// walks the one-hot bit through every position, holding each one for DWELL
// cycles and pulsing wrap when the index rolls over from the top back to 0.
module decoder_nx2n_scan #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      in,
    input  logic              in_valid,
    output logic [(1<<N)-1:0] out,
    output logic              out_valid,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int W  = 1 << N;
    // Dwell counter width; a DWELL of 1 still needs a 1-bit register.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_MAX  = {N{1'b1}};
    localparam logic [W-1:0]  ONE_HOT0 = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  idx_next;

    assign idx_next = idx + 1'b1;

    // Mode state machine; every output is a register updated in this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OFF;
            out       <= '0;
            out_valid <= 1'b0;
            idx       <= '0;
            wrap      <= 1'b0;
            cnt       <= '0;
        end else if (!en) begin
            // Disabled: blank the output, keep idx and the dwell count.
            state     <= OFF;
            out       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (!mode) begin
            // Direct decode; a missing in_valid keeps the last position.
            state <= DIRECT;
            cnt   <= '0;
            wrap  <= 1'b0;
            if (in_valid) begin
                out       <= ONE_HOT0 << in;
                idx       <= in;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (state != SCAN) begin
            // Scan always starts fresh from position 0, never resumes.
            state     <= SCAN;
            idx       <= '0;
            out       <= ONE_HOT0;
            cnt       <= '0;
            out_valid <= 1'b1;
            wrap      <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                idx  <= idx_next;
                out  <= ONE_HOT0 << idx_next;
                wrap <= (idx == IDX_MAX);
            end else begin
                cnt  <= cnt + 1'b1;
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// tb_decoder_nx2n_scan: directed vectors with hand-computed expectations for
// decoder_nx2n_scan at N=3. One instance uses DWELL=4, a second DWELL=1.
module tb_decoder_nx2n_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] in_sel;
    logic       in_valid;
    logic [7:0] out;
    logic       out_valid;
    logic [2:0] idx;
    logic       wrap;

    logic       rst1;
    logic       en1;
    logic       mode1;
    logic [7:0] out1;
    logic       out_valid1;
    logic [2:0] idx1;
    logic       wrap1;

    int compared   = 0;
    int mismatched = 0;

    decoder_nx2n_scan #(.N(3), .DWELL(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in        (in_sel),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .idx       (idx),
        .wrap      (wrap)
    );

    decoder_nx2n_scan #(.N(3), .DWELL(1)) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .en        (en1),
        .mode      (mode1),
        .in        (in_sel),
        .in_valid  (in_valid),
        .out       (out1),
        .out_valid (out_valid1),
        .idx       (idx1),
        .wrap      (wrap1)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic m,
                                 input logic [2:0] s, input logic v);
        en       = e;
        mode     = m;
        in_sel   = s;
        in_valid = v;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        rst1  = 1'b1;
        en1   = 1'b1;
        mode1 = 1'b1;
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);

        // Reset held for two edges while scan is requested
        tick();
        tick();
        checkOutput("rst_out",       64'(out),       64'h00);
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_idx",       64'(idx),       64'h0);
        checkOutput("rst_wrap",      64'(wrap),      64'h0);
        rst = 1'b0;
        tick();
        checkOutput("rel_out",       64'(out),       64'h01);
        checkOutput("rel_out_valid", 64'(out_valid), 64'h1);

        // Direct sweep, entered straight from scan with in_valid high
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 3'(i), 1'b1);
            tick();
            checkOutput("dir_out",       64'(out),       64'(8'h01 << i));
            checkOutput("dir_idx",       64'(idx),       64'(i));
            checkOutput("dir_out_valid", 64'(out_valid), 64'h1);
            checkOutput("dir_wrap",      64'(wrap),      64'h0);
        end
        applyStimulus(1'b1, 1'b0, 3'd2, 1'b0);
        tick();
        checkOutput("gap_out",       64'(out),       64'h80);
        checkOutput("gap_out_valid", 64'(out_valid), 64'h0);

        // Scan sweep: 4 cycles per position, wrap on the 32nd edge after entry
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            tick();
            checkOutput("scan_out",       64'(out),       64'(8'h01 << ((c / 4) % 8)));
            checkOutput("scan_idx",       64'(idx),       64'((c / 4) % 8));
            checkOutput("scan_out_valid", 64'(out_valid), 64'h1);
            checkOutput("scan_wrap",      64'(wrap),      64'(c == 32));
        end

        // Disable mid-scan at idx 5, then restart from position 0
        applyStimulus(1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        checkOutput("off_out", 64'(out), 64'h00);
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
        tick();
        checkOutput("reentry_out", 64'(out), 64'h01);
        for (int c = 0; c < 20; c++) tick();
        checkOutput("pre_dis_idx", 64'(idx), 64'h5);
        checkOutput("pre_dis_out", 64'(out), 64'h20);
        applyStimulus(1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        checkOutput("dis_out",       64'(out),       64'h00);
        checkOutput("dis_out_valid", 64'(out_valid), 64'h0);
        checkOutput("dis_idx_hold",  64'(idx),       64'h5);
        checkOutput("dis_wrap",      64'(wrap),      64'h0);
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
        tick();
        checkOutput("restart_out",       64'(out),       64'h01);
        checkOutput("restart_idx",       64'(idx),       64'h0);
        checkOutput("restart_out_valid", 64'(out_valid), 64'h1);

        // Mode switch from scan at idx 3 with no valid select
        for (int c = 0; c < 12; c++) tick();
        checkOutput("pre_sw_out", 64'(out), 64'h08);
        applyStimulus(1'b1, 1'b0, 3'd6, 1'b0);
        tick();
        checkOutput("sw_out_hold",  64'(out),       64'h08);
        checkOutput("sw_idx_hold",  64'(idx),       64'h3);
        checkOutput("sw_out_valid", 64'(out_valid), 64'h0);
        applyStimulus(1'b1, 1'b0, 3'd6, 1'b1);
        tick();
        checkOutput("sw_dec_out",       64'(out),       64'h40);
        checkOutput("sw_dec_idx",       64'(idx),       64'h6);
        checkOutput("sw_dec_out_valid", 64'(out_valid), 64'h1);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);

        // DWELL=1 instance: advance every cycle, wrap every 8, reset mid-sweep
        checkOutput("d1_rst_out", 64'(out1), 64'h00);
        rst1 = 1'b0;
        for (int c = 0; c < 18; c++) begin
            tick();
            checkOutput("d1_out",  64'(out1),  64'(8'h01 << (c % 8)));
            checkOutput("d1_wrap", 64'(wrap1), 64'(c == 8 || c == 16));
        end
        rst1 = 1'b1;
        tick();
        checkOutput("d1_mid_rst_out",       64'(out1),       64'h00);
        checkOutput("d1_mid_rst_out_valid", 64'(out_valid1), 64'h0);
        checkOutput("d1_mid_rst_idx",       64'(idx1),       64'h0);
        checkOutput("d1_mid_rst_wrap",      64'(wrap1),      64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
